// File: rtl/prime_pkg.sv
// Shared definitions for the sequential prime checker: FSM state encoding and default width.
package prime_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StDiv,
    StEval,
    StDone
  } state_e;

endpackage

// File: rtl/rem_unit.sv
// Restoring shift-subtract remainder unit: one quotient bit per cycle, valid WIDTH cycles after start.
module rem_unit #(
  parameter int unsigned WIDTH = prime_pkg::DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             valid
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [WIDTH-1:0] step_rem, step_bits, step_div;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_next, bits_next;

  // The first step is taken on the start edge itself so valid lands exactly WIDTH cycles later.
  always_comb begin
    step_rem  = start ? '0 : rem_q;
    step_bits = start ? dividend : bits_q;
    step_div  = start ? divisor : div_q;
    shifted   = {step_rem, step_bits[WIDTH-1]};
    ge        = shifted >= {1'b0, step_div};
    // The difference is below the divisor, so only its low WIDTH bits matter.
    rem_next  = ge ? (shifted[WIDTH-1:0] - step_div) : shifted[WIDTH-1:0];
    bits_next = {step_bits[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    rem_d  = rem_q;
    bits_d = bits_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    if (start) begin
      rem_d  = rem_next;
      bits_d = bits_next;
      div_d  = divisor;
      cnt_d  = CntW'(WIDTH - 1);
      run_d  = 1'b1;
    end else if (run_q && (cnt_q != '0)) begin
      rem_d  = rem_next;
      bits_d = bits_next;
      cnt_d  = cnt_q - CntW'(1);
    end else if (run_q) begin
      run_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      bits_q <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      bits_q <= bits_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign rem   = rem_q;
  assign valid = run_q && (cnt_q == '0);

endmodule

// File: rtl/prime_checker_seq.sv
// Sequential primality tester: trial division d = 2, 3, ... while d*d <= A, one remainder per trial.
module prime_checker_seq
  import prime_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic [WIDTH-1:0] factor
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             prime_q, prime_d;
  logic [WIDTH-1:0] factor_q, factor_d;

  logic             rem_start;
  logic [WIDTH-1:0] rem;
  logic             rem_valid;

  logic [2*WIDTH-1:0] d_sq;
  logic [2*WIDTH-1:0] a_ext;

  assign d_sq  = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
  assign a_ext = {{WIDTH{1'b0}}, a_q};

  rem_unit #(
    .WIDTH(WIDTH)
  ) u_rem_unit (
    .clk     (clk),
    .rst     (rst),
    .start   (rem_start),
    .dividend(a_q),
    .divisor (d_q),
    .rem     (rem),
    .valid   (rem_valid)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    d_d       = d_q;
    prime_d   = prime_q;
    factor_d  = factor_q;
    rem_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d      = A;
          d_d      = WIDTH'(2);
          prime_d  = 1'b0;
          factor_d = '0;
          state_d  = StCheck;
        end
      end
      StCheck: begin
        if (a_q < WIDTH'(2)) begin
          prime_d  = 1'b0;
          factor_d = '0;
          state_d  = StDone;
        end else if (factor_q != '0) begin
          // A divisor was found in the last EVAL; every run exits from CHECK.
          state_d  = StDone;
        end else if (d_sq > a_ext) begin
          prime_d  = 1'b1;
          factor_d = '0;
          state_d  = StDone;
        end else begin
          rem_start = 1'b1;
          state_d   = StDiv;
        end
      end
      StDiv: begin
        if (rem_valid) begin
          state_d = StEval;
        end
      end
      StEval: begin
        if (rem == '0) begin
          prime_d  = 1'b0;
          factor_d = d_q;
        end else begin
          d_d = d_q + WIDTH'(1);
        end
        state_d = StCheck;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      d_q      <= '0;
      prime_q  <= 1'b0;
      factor_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      d_q      <= d_d;
      prime_q  <= prime_d;
      factor_q <= factor_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign is_prime = prime_q;
  assign factor   = factor_q;

endmodule

// File: tb/tb_prime_checker_seq.sv
// Scoreboard bench for prime_checker_seq: a stimulus process queues expected results, a monitor checks them.
module tb_prime_checker_seq;

  localparam int unsigned W           = 8;
  localparam int unsigned TrialCycles = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic         busy;
  logic         done;
  logic         is_prime;
  logic [W-1:0] factor;

  prime_checker_seq #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .busy    (busy),
    .done    (done),
    .is_prime(is_prime),
    .factor  (factor)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    bit          prime;
    int unsigned factor;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  bit          have_last = 1'b0;
  bit          last_p;
  int unsigned last_f;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain trial division counting how many divisors get tried.
  function automatic exp_t model(input int unsigned a);
    exp_t        e;
    int unsigned n;
    e.a      = a;
    e.prime  = 1'b0;
    e.factor = 0;
    e.acc    = 0;
    n        = 0;
    if (a >= 2) begin
      e.prime = 1'b1;
      for (int unsigned d = 2; d * d <= a; d++) begin
        n++;
        if (a % d == 0) begin
          e.prime  = 1'b0;
          e.factor = d;
          break;
        end
      end
    end
    e.lat = 2 + n * TrialCycles;
    return e;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done) begin
        check("busy_at_done", busy, 1);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1, required no result pending (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("is_prime(A=%0d)", e.a), is_prime, e.prime);
          check($sformatf("factor(A=%0d)", e.a), factor, e.factor);
          check($sformatf("latency(A=%0d)", e.a), cyc - e.acc, e.lat);
          have_last = 1'b1;
          last_p    = e.prime;
          last_f    = e.factor;
        end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].acc) begin
        check("busy_in_flight", busy, 1);
      end else if (!busy && have_last) begin
        check("stable_is_prime", is_prime, last_p);
        check("stable_factor", factor, last_f);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no done after %0d cycles, required done", n);
      sb_q.delete();
    end
  endtask

  task automatic do_op(input int unsigned a, input int unsigned gap, input bit noise);
    exp_t e;
    e     = model(a);
    e.acc = cyc;
    sb_q.push_back(e);
    start = 1'b1;
    A     = W'(a);
    @(negedge clk);
    start = 1'b0;
    A     = W'($urandom);
    if (noise) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      A     = W'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
    repeat (gap) @(negedge clk);
  endtask

  int unsigned directed[9] = '{0, 1, 2, 3, 4, 9, 11, 255, 251};

  initial begin
    int unsigned a;
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_is_prime", is_prime, 0);
    check("reset_factor", factor, 0);
    @(negedge clk);

    foreach (directed[i]) do_op(directed[i], 1, 1'b0);
    do_op(77, 4, 1'b1);
    do_op(200, 1, 1'b1);
    do_op(121, 3, 1'b1);

    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(0, 255);
      do_op(a, $urandom_range(1, 3), (a >= 4) && ($urandom_range(0, 1) == 1));
    end

    // Reset in the middle of a division, then a fresh operation.
    start = 1'b1;
    A     = W'(251);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    have_last = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_is_prime", is_prime, 0);
    check("midrst_factor", factor, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(12, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
